// File: rtl/alu_bridge_pkg.sv
// rtl/alu_bridge_pkg.sv - shared opcodes, status codes and FSM encoding for the ALU/UART bridge
package alu_bridge_pkg;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE      = 3'd0,
        ST_GET_A     = 3'd1,
        ST_GET_B     = 3'd2,
        ST_EXEC      = 3'd3,
        ST_SEND_REQ  = 3'd4,
        ST_SEND_WAIT = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    localparam logic [7:0] STATUS_OK         = 8'h00;
    localparam logic [7:0] STATUS_BAD_OPCODE = 8'h01;

endpackage

// File: rtl/alu_uart_bridge_if.sv
// rtl/alu_uart_bridge_if.sv - uart-side byte handshake between the uart and the bridge
interface alu_uart_bridge_if #(
    parameter int NB_DATA = 8
);
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_data;
    logic               o_busy;
    logic               o_err;

    // master is the uart side, slave is the bridge
    modport master (
        output i_rx_done, i_data, i_tx_done,
        input  o_tx_start, o_data, o_busy, o_err
    );

    modport slave (
        input  i_rx_done, i_data, i_tx_done,
        output o_tx_start, o_data, o_busy, o_err
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational W-bit ALU with opcode validity flag
module alu_core
    import alu_bridge_pkg::*;
#(
    parameter int W       = 16,
    parameter int NB_CODE = 6
) (
    input  logic [W-1:0]       i_a,
    input  logic [W-1:0]       i_b,
    input  logic [NB_CODE-1:0] i_op,
    output logic [W-1:0]       o_res,
    output logic               o_valid_op
);

    localparam logic [W-1:0] W_LIM = W'(W);

    logic shift_ovf;
    assign shift_ovf = (i_b >= W_LIM);

    always_comb begin
        o_res      = '0;
        o_valid_op = 1'b1;
        case (i_op)
            NB_CODE'(OP_ADD): o_res = i_a + i_b;
            NB_CODE'(OP_SUB): o_res = i_a - i_b;
            NB_CODE'(OP_AND): o_res = i_a & i_b;
            NB_CODE'(OP_OR):  o_res = i_a | i_b;
            NB_CODE'(OP_XOR): o_res = i_a ^ i_b;
            NB_CODE'(OP_NOR): o_res = ~(i_a | i_b);
            NB_CODE'(OP_SRL): o_res = shift_ovf ? '0 : (i_a >> i_b);
            // oversized arithmetic shift saturates to a full sign fill
            NB_CODE'(OP_SRA): o_res = shift_ovf ? {W{i_a[W-1]}} : $unsigned($signed(i_a) >>> i_b);
            default:          o_valid_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_uart_bridge.sv
// rtl/alu_uart_bridge.sv - assembles multi-byte ALU command frames from uart bytes and returns status plus result
module alu_uart_bridge
    import alu_bridge_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_BYTES    = 2,
    parameter int NB_CODE     = 6,
    parameter int NB_TIMEOUT  = 20,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    alu_uart_bridge_if.slave  bus
);

    localparam int W      = NB_DATA * NB_BYTES;
    localparam int NB_CNT = $clog2(NB_BYTES + 1);

    localparam logic [NB_CNT-1:0]     LAST_BYTE = NB_CNT'(NB_BYTES - 1);
    localparam logic [NB_CNT-1:0]     N_RES     = NB_CNT'(NB_BYTES);
    localparam logic [NB_TIMEOUT-1:0] TOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYC - 1);

    state_t              state;
    logic [NB_DATA-1:0]  opcode;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [W-1:0]        tx_sr;
    logic [NB_CNT-1:0]   byte_cnt;
    logic [NB_CNT-1:0]   tx_cnt;
    logic [NB_TIMEOUT-1:0] tout_cnt;
    logic [W-1:0]        alu_res;
    logic                alu_valid;
    logic                bad_op;
    logic [W-1:0]        rx_shifted_a;
    logic [W-1:0]        rx_shifted_b;

    alu_core #(
        .W       (W),
        .NB_CODE (NB_CODE)
    ) u_alu (
        .i_a        (a_reg),
        .i_b        (b_reg),
        .i_op       (opcode[NB_CODE-1:0]),
        .o_res      (alu_res),
        .o_valid_op (alu_valid)
    );

    // opcode byte MSBs above the code field must be clear
    assign bad_op = (opcode[NB_DATA-1:NB_CODE] != '0) || !alu_valid;

    // new byte enters at the top so the first (LSB) byte ends up at bit 0
    assign rx_shifted_a = (a_reg >> NB_DATA) | (W'(bus.i_data) << (W - NB_DATA));
    assign rx_shifted_b = (b_reg >> NB_DATA) | (W'(bus.i_data) << (W - NB_DATA));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            opcode         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            tx_sr          <= '0;
            byte_cnt       <= '0;
            tx_cnt         <= '0;
            tout_cnt       <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_data     <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_err      <= 1'b0;
        end else begin
            bus.o_tx_start <= 1'b0;
            bus.o_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_rx_done) begin
                        opcode     <= bus.i_data;
                        byte_cnt   <= '0;
                        tout_cnt   <= '0;
                        bus.o_busy <= 1'b1;
                        state      <= ST_GET_A;
                    end
                end
                ST_GET_A, ST_GET_B: begin
                    // the timeout outranks a byte arriving in the same cycle
                    if (tout_cnt == TOUT_LAST) begin
                        tout_cnt   <= '0;
                        byte_cnt   <= '0;
                        bus.o_err  <= 1'b1;
                        bus.o_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (bus.i_rx_done) begin
                        tout_cnt <= '0;
                        if (state == ST_GET_A) a_reg <= rx_shifted_a;
                        else                   b_reg <= rx_shifted_b;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            if (state == ST_GET_A) begin
                                state <= ST_GET_B;
                            end else begin
                                bus.o_err <= bad_op;
                                state     <= ST_EXEC;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    tx_sr          <= bad_op ? '0 : alu_res;
                    bus.o_data     <= bad_op ? NB_DATA'(STATUS_BAD_OPCODE) : NB_DATA'(STATUS_OK);
                    bus.o_tx_start <= 1'b1;
                    tx_cnt         <= '0;
                    state          <= ST_SEND_REQ;
                end
                ST_SEND_REQ: begin
                    state <= ST_SEND_WAIT;
                end
                ST_SEND_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (tx_cnt == N_RES) begin
                            bus.o_busy <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            bus.o_data     <= tx_sr[NB_DATA-1:0];
                            tx_sr          <= tx_sr >> NB_DATA;
                            tx_cnt         <= tx_cnt + 1'b1;
                            bus.o_tx_start <= 1'b1;
                            state          <= ST_SEND_REQ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
